matrix_frame_store: RTL and testbench

MATRIX_FRAME_STORE -- requirements
Module: matrix_frame_store

---
 rtl/matrix_frame_store.sv | 162 ++++++++++++++++
 tb/tb_matrix_frame_store.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_store.sv
// Double-buffered 8x16 LED matrix frame store with a 32-bit seven-segment shadow.
// Commands edit the back buffer; a swap copies it to the front on a renderer frame tick.
module matrix_frame_store (
  input  logic        clockin,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_row,
  input  logic [3:0]  cmd_col,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  input  logic        swap_req,
  input  logic        frame_tick,
  input  logic        sev_load,
  input  logic [31:0] sev_data,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [15:0] R3,
  output logic [15:0] R4,
  output logic [15:0] R5,
  output logic [15:0] R6,
  output logic [15:0] R7,
  output logic [15:0] R8,
  output logic [31:0] SevSeg,
  output logic        swap_done,
  output logic [7:0]  commit_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_WRITE_ROW = 2'b00;
  localparam logic [1:0] OP_SET_PIX   = 2'b01;
  localparam logic [1:0] OP_CLR_PIX   = 2'b10;
  localparam logic [1:0] OP_CLR_ALL   = 2'b11;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_back  [8];
  logic [15:0] r_front [8];
  logic [31:0] r_sevBack;
  logic [31:0] r_sevFront;
  logic        r_swapPend;
  logic [2:0]  r_clrRow;
  logic        r_swapDone;
  logic [7:0]  r_commitCnt;
  logic        w_ready;
  logic        w_accept;
  logic        w_commit;

  assign w_ready  = (r_state == IDLE) && !r_swapPend;
  assign w_accept = cmd_valid && w_ready;

  // A pending swap blocks new commands, so IDLE can only leave for SWAP_WAIT
  // once the command that arrived alongside the request has been taken.
  always_comb begin
    w_nextState = r_state;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (cmd_op == OP_CLR_ALL)) begin
          w_nextState = CLEAR;
        end else if (r_swapPend && !w_accept) begin
          w_nextState = SWAP_WAIT;
        end
      end
      CLEAR: begin
        if (r_clrRow == 3'd7) begin
          w_nextState = r_swapPend ? SWAP_WAIT : IDLE;
        end
      end
      SWAP_WAIT: begin
        if (frame_tick) begin
          w_commit    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      r_state     <= IDLE;
      r_swapPend  <= 1'b0;
      r_clrRow    <= 3'd0;
      r_swapDone  <= 1'b0;
      r_commitCnt <= 8'd0;
    end else begin
      r_state     <= w_nextState;
      r_swapPend  <= (r_swapPend && !w_commit) || swap_req;
      r_swapDone  <= w_commit;
      r_clrRow    <= (r_state == CLEAR) ? r_clrRow + 3'd1 : 3'd0;
      if (w_commit) begin
        r_commitCnt <= r_commitCnt + 8'd1;
      end
    end
  end

  // Back buffer: the row sweep of a clear-all and accepted commands never overlap.
  always_ff @(posedge clockin) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_back[i] <= 16'd0;
      end
    end else if (r_state == CLEAR) begin
      r_back[r_clrRow] <= 16'd0;
    end else if (w_accept) begin
      case (cmd_op)
        OP_WRITE_ROW: r_back[cmd_row]          <= cmd_data;
        OP_SET_PIX:   r_back[cmd_row][cmd_col] <= 1'b1;
        OP_CLR_PIX:   r_back[cmd_row][cmd_col] <= 1'b0;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_front[i] <= 16'd0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        r_front[i] <= r_back[i];
      end
    end
  end

  // A load coinciding with a commit lands in the back register while the
  // front takes the value that was there before the edge.
  always_ff @(posedge clockin) begin
    if (reset) begin
      r_sevBack  <= 32'd0;
      r_sevFront <= 32'd0;
    end else begin
      if (sev_load) begin
        r_sevBack <= sev_data;
      end
      if (w_commit) begin
        r_sevFront <= r_sevBack;
      end
    end
  end

  assign cmd_ready  = w_ready;
  assign swap_done  = r_swapDone;
  assign commit_cnt = r_commitCnt;
  assign SevSeg     = r_sevFront;
  assign R1         = r_front[0];
  assign R2         = r_front[1];
  assign R3         = r_front[2];
  assign R4         = r_front[3];
  assign R5         = r_front[4];
  assign R6         = r_front[5];
  assign R7         = r_front[6];
  assign R8         = r_front[7];

endmodule

// File: tb/tb_matrix_frame_store.sv
// Self-checking bench for matrix_frame_store: directed scenarios plus random
// traffic, all outputs compared every cycle against a behavioural frame-store model.
module tb_matrix_frame_store;

  logic        clockin = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_row;
  logic [3:0]  cmd_col;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        swap_req;
  logic        frame_tick;
  logic        sev_load;
  logic [31:0] sev_data;
  logic [15:0] R1, R2, R3, R4, R5, R6, R7, R8;
  logic [31:0] SevSeg;
  logic        swap_done;
  logic [7:0]  commit_cnt;
  logic [15:0] dutRows [8];

  int checkCount = 0;
  int errorCount = 0;

  // Model: back/front images, seven-segment pair, and progress of the current operation.
  logic [15:0] mBack  [8];
  logic [15:0] mFront [8];
  logic [31:0] mSevBack;
  logic [31:0] mSev;
  logic [7:0]  mCnt;
  logic        mPend;
  logic        mWait;
  logic        mDone;
  int          mClearLeft;
  logic        lastAccepted;

  matrix_frame_store dut (
    .clockin(clockin), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .swap_req(swap_req), .frame_tick(frame_tick), .sev_load(sev_load), .sev_data(sev_data),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7), .R8(R8),
    .SevSeg(SevSeg), .swap_done(swap_done), .commit_cnt(commit_cnt)
  );

  always #5 clockin = ~clockin;

  always_comb begin
    dutRows[0] = R1; dutRows[1] = R2; dutRows[2] = R3; dutRows[3] = R4;
    dutRows[4] = R5; dutRows[5] = R6; dutRows[6] = R7; dutRows[7] = R8;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic modelReady();
    return (mClearLeft == 0) && !mWait && !mPend;
  endfunction

  task automatic modelStep();
    logic oldPend, oldWait, commit;
    int   oldClear;
    lastAccepted = 1'b0;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mBack[i]  = 16'd0;
        mFront[i] = 16'd0;
      end
      mSevBack = 32'd0; mSev = 32'd0; mCnt = 8'd0;
      mPend = 1'b0; mWait = 1'b0; mDone = 1'b0; mClearLeft = 0;
      return;
    end
    oldPend  = mPend;
    oldWait  = mWait;
    oldClear = mClearLeft;
    commit   = oldWait && frame_tick;
    mDone    = commit;
    if (commit) begin
      for (int i = 0; i < 8; i++) mFront[i] = mBack[i];
      mSev  = mSevBack;
      mCnt  = mCnt + 8'd1;
      mWait = 1'b0;
    end
    if (sev_load) mSevBack = sev_data;
    if (oldClear > 0) begin
      mBack[8 - oldClear] = 16'd0;
      mClearLeft = oldClear - 1;
      if (mClearLeft == 0 && oldPend) mWait = 1'b1;
    end else if (!oldWait) begin
      if (cmd_valid && !oldPend) begin
        lastAccepted = 1'b1;
        case (cmd_op)
          2'b00: mBack[cmd_row] = cmd_data;
          2'b01: mBack[cmd_row][cmd_col] = 1'b1;
          2'b10: mBack[cmd_row][cmd_col] = 1'b0;
          default: mClearLeft = 8;
        endcase
      end else if (oldPend) begin
        mWait = 1'b1;
      end
    end
    mPend = (oldPend && !commit) || swap_req;
  endtask

  task automatic checkAll();
    checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, modelReady()});
    checkOutput("swap_done", {31'd0, swap_done}, {31'd0, mDone});
    checkOutput("commit_cnt", {24'd0, commit_cnt}, {24'd0, mCnt});
    checkOutput("SevSeg", SevSeg, mSev);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("R%0d", i + 1), {16'd0, dutRows[i]}, {16'd0, mFront[i]});
    end
  endtask

  // One clock: model and DUT advance on the same edge, outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clockin);
    modelStep();
    @(negedge clockin);
    checkAll();
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] row, input logic [3:0] col,
                               input logic [15:0] data);
    bit done = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data;
    for (int n = 0; n < 40 && !done; n++) begin
      cycle();
      done = lastAccepted;
    end
    cmd_valid = 1'b0;
    if (!done) checkOutput("cmdTimeout", 32'd0, 32'd1);
  endtask

  task automatic commitNow();
    bit done = 0;
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    frame_tick = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      cycle();
      done = mDone;
    end
    frame_tick = 1'b0;
    if (!done) checkOutput("commitTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int doneCount;
    logic [7:0] cntBefore;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_row = 3'd0; cmd_col = 4'd0;
    cmd_data = 16'd0; swap_req = 1'b0; frame_tick = 1'b0; sev_load = 1'b0; sev_data = 32'd0;
    mClearLeft = 0; mPend = 1'b0; mWait = 1'b0; mDone = 1'b0; lastAccepted = 1'b0;
    @(negedge clockin);
    applyReset();
    checkOutput("rstReady", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rstCnt", {24'd0, commit_cnt}, 32'd0);

    $display("[TB] write row 3 and commit");
    applyStimulus(2'b00, 3'd3, 4'd0, 16'hA5C3);
    swap_req = 1'b1; cycle();
    swap_req = 1'b0; cycle();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0;
    checkOutput("s1R4", {16'd0, R4}, 32'h0000A5C3);
    checkOutput("s1R1", {16'd0, R1}, 32'd0);
    checkOutput("s1Done", {31'd0, swap_done}, 32'd1);
    checkOutput("s1Cnt", {24'd0, commit_cnt}, 32'd1);
    cycle();
    checkOutput("s1DoneLow", {31'd0, swap_done}, 32'd0);

    $display("[TB] pixel set/clear");
    applyStimulus(2'b01, 3'd0, 4'd15, 16'hFFFF);
    applyStimulus(2'b10, 3'd0, 4'd15, 16'hFFFF);
    applyStimulus(2'b01, 3'd0, 4'd0, 16'h0000);
    commitNow();
    checkOutput("s2R1", {16'd0, R1}, 32'h00000001);

    $display("[TB] fill, commit, clear all");
    for (int r = 0; r < 8; r++) applyStimulus(2'b00, 3'(r), 4'd0, 16'hFFFF);
    commitNow();
    applyStimulus(2'b11, 3'd0, 4'd0, 16'd0);
    for (int n = 0; n < 8; n++) begin
      checkOutput("s3ReadyLow", {31'd0, cmd_ready}, 32'd0);
      cycle();
    end
    checkOutput("s3Held", {16'd0, R8}, 32'h0000FFFF);
    commitNow();
    checkOutput("s3R1", {16'd0, R1}, 32'd0);
    checkOutput("s3R8", {16'd0, R8}, 32'd0);

    $display("[TB] swap during clear");
    for (int r = 0; r < 8; r++) applyStimulus(2'b00, 3'(r), 4'd0, 16'(r * 16'h1111));
    cntBefore = commit_cnt;
    applyStimulus(2'b11, 3'd0, 4'd0, 16'd0);
    doneCount = 0;
    for (int i = 0; i < 24; i++) begin
      swap_req = (i == 3);
      frame_tick = (i % 4 == 0);
      cycle();
      if (swap_done) doneCount++;
    end
    swap_req = 1'b0; frame_tick = 1'b0;
    checkOutput("s4DoneCount", doneCount, 32'd1);
    checkOutput("s4Cnt", {24'd0, commit_cnt}, {24'd0, cntBefore + 8'd1});
    checkOutput("s4R3", {16'd0, R3}, 32'd0);

    $display("[TB] seven-segment on commit edge");
    sev_load = 1'b1; sev_data = 32'h0000BEEF; cycle();
    sev_load = 1'b0;
    swap_req = 1'b1; cycle();
    swap_req = 1'b0; cycle();
    frame_tick = 1'b1; sev_load = 1'b1; sev_data = 32'h12345678; cycle();
    frame_tick = 1'b0; sev_load = 1'b0;
    checkOutput("s5Sev1", SevSeg, 32'h0000BEEF);
    commitNow();
    checkOutput("s5Sev2", SevSeg, 32'h12345678);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      cmd_valid  = $urandom_range(0, 1);
      cmd_op     = 2'($urandom_range(0, 3));
      cmd_row    = 3'($urandom);
      cmd_col    = 4'($urandom);
      cmd_data   = 16'($urandom);
      swap_req   = ($urandom_range(0, 9) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      sev_load   = ($urandom_range(0, 9) == 0);
      sev_data   = $urandom;
      cycle();
    end
    reset = 1'b0; cmd_valid = 1'b0; swap_req = 1'b0; frame_tick = 1'b0; sev_load = 1'b0;

    $display("[TB] 256 commits and reset in SWAP_WAIT");
    applyReset();
    applyStimulus(2'b00, 3'd5, 4'd0, 16'h1234);
    sev_load = 1'b1; sev_data = 32'hCAFE0001; cycle();
    sev_load = 1'b0;
    for (int n = 0; n < 256; n++) commitNow();
    checkOutput("s6Wrap", {24'd0, commit_cnt}, 32'd0);
    checkOutput("s6R6", {16'd0, R6}, 32'h00001234);
    swap_req = 1'b1; cycle();
    swap_req = 1'b0; cycle();
    reset = 1'b1; frame_tick = 1'b1; cycle();
    reset = 1'b0; frame_tick = 1'b0;
    checkOutput("s6RstR6", {16'd0, R6}, 32'd0);
    checkOutput("s6RstSev", SevSeg, 32'd0);
    checkOutput("s6RstDone", {31'd0, swap_done}, 32'd0);
    checkOutput("s6RstReady", {31'd0, cmd_ready}, 32'd1);
    frame_tick = 1'b1; cycle(); cycle();
    frame_tick = 1'b0;
    checkOutput("s6NoCommit", {24'd0, commit_cnt}, 32'd0);
    checkOutput("s6NoDone", {31'd0, swap_done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
